// File: rtl/mem_responder_ws.sv
// Byte-addressable memory responder with programmable wait states.
// Accepts a MOV request, waits WAIT_STATES cycles, commits the read or
// write, then pulses MOC for one cycle. Big-endian, byte/half/word,
// optional sign extension on narrow loads, misalignment/range errors.
//
// Handshake: the initiator raises MOV and holds it until it sees MOC.
// The request is latched on the first edge MOV is seen in IDLE; inputs
// are ignored afterwards. After MOC, MOV must be low for at least one
// edge before another request is accepted (HOLD state).
module mem_responder_ws #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MOV,
  input  logic        ReadWrite,
  input  logic [2:0]  MS,
  input  logic [31:0] DataIn,
  input  logic [31:0] Address,
  output logic        MOC,
  output logic        ERR,
  output logic [31:0] DataOut,
  output logic        BUSY,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t state, next_state;

  logic [7:0]        memory [0:(1<<ADDR_W)-1];

  logic [31:0]       lat_addr;
  logic              lat_rw;
  logic [2:0]        lat_ms;
  logic [31:0]       lat_data;
  logic [3:0]        cnt;

  logic [ADDR_W-1:0] idx0, idx1, idx2, idx3;
  logic              req_err;
  logic              commit;
  logic [7:0]        b0, b1, b2, b3;
  logic [31:0]       rd_val;

  assign idx0 = lat_addr[ADDR_W-1:0];
  assign idx1 = idx0 + ADDR_W'(1);
  assign idx2 = idx0 + ADDR_W'(2);
  assign idx3 = idx0 + ADDR_W'(3);

  assign commit    = (state == ST_BUSY) && (cnt == 4'd0);
  assign BUSY      = (state == ST_BUSY) || (state == ST_DONE);
  assign state_dbg = state;

  // Reject reserved size, misaligned half/word and out-of-range addresses.
  always_comb begin
    req_err = 1'b0;
    if (lat_ms[1:0] == 2'b11) req_err = 1'b1;
    if (lat_ms[1:0] == 2'b01 && lat_addr[0]) req_err = 1'b1;
    if (lat_ms[1:0] == 2'b10 && lat_addr[1:0] != 2'b00) req_err = 1'b1;
    if ((lat_addr >> ADDR_W) != 32'd0) req_err = 1'b1;
  end

  // Big-endian read assembly with zero/sign extension of narrow loads.
  always_comb begin
    b0 = memory[idx0];
    b1 = memory[idx1];
    b2 = memory[idx2];
    b3 = memory[idx3];
    rd_val = {b0, b1, b2, b3};
    case (lat_ms[1:0])
      2'b00:   rd_val = {{24{lat_ms[2] & b0[7]}}, b0};
      2'b01:   rd_val = {{16{lat_ms[2] & b0[7]}}, b0, b1};
      default: rd_val = {b0, b1, b2, b3};
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (MOV) next_state = ST_BUSY;
      ST_BUSY: if (cnt == 4'd0) next_state = ST_DONE;
      ST_DONE: next_state = MOV ? ST_HOLD : ST_IDLE;
      ST_HOLD: if (!MOV) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Request latch and wait-state counter.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      lat_addr <= '0;
      lat_rw   <= 1'b0;
      lat_ms   <= '0;
      lat_data <= '0;
      cnt      <= '0;
    end else if (state == ST_IDLE && MOV) begin
      lat_addr <= Address;
      lat_rw   <= ReadWrite;
      lat_ms   <= MS;
      lat_data <= DataIn;
      cnt      <= 4'(WAIT_STATES);
    end else if (state == ST_BUSY && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Completion outputs; DataOut only moves on a successful read.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      MOC     <= 1'b0;
      ERR     <= 1'b0;
      DataOut <= '0;
    end else begin
      MOC <= commit;
      ERR <= commit & req_err;
      if (commit && !req_err && lat_rw) DataOut <= rd_val;
    end
  end

  // Storage writes; only the addressed bytes change. Not reset.
  always_ff @(posedge CLK) begin
    if (commit && !req_err && !lat_rw) begin
      case (lat_ms[1:0])
        2'b00: memory[idx0] <= lat_data[7:0];
        2'b01: begin
          memory[idx0] <= lat_data[15:8];
          memory[idx1] <= lat_data[7:0];
        end
        default: begin
          memory[idx0] <= lat_data[31:24];
          memory[idx1] <= lat_data[23:16];
          memory[idx2] <= lat_data[15:8];
          memory[idx3] <= lat_data[7:0];
        end
      endcase
    end
  end

endmodule
